// File: rtl/mux_scan_if.sv
`default_nettype none
// ============================================================================
// Module      : mux_scan_if
// Description : Bundle of signals between the scan sequencer and its user / mux.
//               The sequencer (slave side) receives start, scan_mask and the mux
//               out line, and drives the mux select lines and the scan result.
//   start      - scan request
//   scan_mask  - channel enables, bit i = mux in<i>
//   mux_out    - mux out line
//   address0/1 - mux select lines
//   sample     - captured result, bit i = channel i
//   valid      - one-cycle pulse when sample holds a new result
//   busy       - scan in progress
// Revision    : 1.0 - initial release
// ============================================================================
interface mux_scan_if;
  logic       start;
  logic [3:0] scan_mask;
  logic       mux_out;
  logic       address0;
  logic       address1;
  logic [3:0] sample;
  logic       valid;
  logic       busy;

  modport master (
    output start, scan_mask, mux_out,
    input  address0, address1, sample, valid, busy
  );

  modport slave (
    input  start, scan_mask, mux_out,
    output address0, address1, sample, valid, busy
  );
endinterface
`default_nettype wire

// File: rtl/mux_scan_controller.sv
`default_nettype none
// ============================================================================
// Module      : mux_scan_controller
// Description : Walks the enabled channels of a 4:1 mux in ascending order,
//               holding each select address for SETTLE_CYCLES clocks before
//               capturing the mux output, then presents the 4-bit result with
//               a one-cycle valid pulse.
//   clk   - rising-edge clock
//   reset - synchronous, active-high reset
//   bus   - mux_scan_if.slave (start/scan_mask/mux_out in; address0/address1/
//           sample/valid/busy out)
// Revision    : 1.0 - initial release
// ============================================================================
module mux_scan_controller #(
  parameter int SETTLE_CYCLES = 3   // legal range 1..15
) (
  input  wire logic   clk,
  input  wire logic   reset,
  mux_scan_if.slave   bus
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  // Counter value on the edge that performs the capture.
  localparam logic [3:0] c_lastCount = 4'(SETTLE_CYCLES - 1);

  logic [1:0] r_state;
  logic [3:0] r_mask;
  logic [3:0] r_shadow;
  logic [3:0] r_sample;
  logic [1:0] r_addr;
  logic [3:0] r_count;

  logic [1:0] w_firstChan;
  logic [1:0] w_nextChan;
  logic       w_hasNext;
  logic [3:0] w_shadowNext;

  // Lowest enabled channel of the incoming mask (used on the accept edge,
  // before the mask has been latched).
  always_comb begin
    w_firstChan = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (bus.scan_mask[i]) w_firstChan = 2'(i);
    end
  end

  // Lowest enabled channel strictly above the current address; disabled
  // channels are skipped so they cost no settle time.
  always_comb begin
    w_hasNext  = 1'b0;
    w_nextChan = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (r_mask[i] && (i > int'(r_addr))) begin
        w_hasNext  = 1'b1;
        w_nextChan = 2'(i);
      end
    end
  end

  // Shadow including the capture happening on this edge, so the final
  // channel lands in sample on the same edge it is captured.
  always_comb begin
    w_shadowNext         = r_shadow;
    w_shadowNext[r_addr] = bus.mux_out;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_mask   <= 4'd0;
      r_shadow <= 4'd0;
      r_sample <= 4'd0;
      r_addr   <= 2'd0;
      r_count  <= 4'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_mask   <= bus.scan_mask;
            r_shadow <= 4'd0;
            if (bus.scan_mask != 4'd0) begin
              r_addr  <= w_firstChan;
              r_count <= 4'd0;
              r_state <= ST_SETTLE;
            end else begin
              // Address lines deliberately left on the last scanned channel.
              r_sample <= 4'd0;
              r_state  <= ST_DONE;
            end
          end
        end
        ST_SETTLE: begin
          if (r_count == c_lastCount) begin
            r_shadow <= w_shadowNext;
            if (w_hasNext) begin
              r_addr  <= w_nextChan;
              r_count <= 4'd0;
            end else begin
              r_sample <= w_shadowNext;
              r_state  <= ST_DONE;
            end
          end else begin
            r_count <= r_count + 4'd1;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.address0 = r_addr[0];
  assign bus.address1 = r_addr[1];
  assign bus.sample   = r_sample;
  assign bus.valid    = (r_state == ST_DONE);
  assign bus.busy     = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mux_scan_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_mux_scan_controller
// Description : Directed bench for mux_scan_controller with a gate-level 4:1
//               mux model (50-unit gate delays, 100-unit clock).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mux_scan_controller;

  logic       clk;
  logic       reset;
  logic [3:0] inVec;
  int         total;
  int         bad;

  mux_scan_if bus();

  mux_scan_controller #(.SETTLE_CYCLES(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Structural 4:1 mux: inverter, 3-input AND, 4-input OR, 50 units each.
  logic nA0, nA1, t0, t1, t2, t3;
  assign #50 nA0 = ~bus.address0;
  assign #50 nA1 = ~bus.address1;
  assign #50 t0  = inVec[0] & nA1 & nA0;
  assign #50 t1  = inVec[1] & nA1 & bus.address0;
  assign #50 t2  = inVec[2] & bus.address1 & nA0;
  assign #50 t3  = inVec[3] & bus.address1 & bus.address0;
  assign #50 bus.mux_out = t0 | t1 | t2 | t3;

  initial clk = 1'b0;
  always #50 clk = ~clk;

  function automatic logic [1:0] curAddr();
    return {bus.address1, bus.address0};
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    bus.start = 1'b0;
    bus.scan_mask = 4'b0000;
    inVec = 4'b0000;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    total++; if (curAddr() !== 2'd0) begin bad++; $display("FAIL reset_addr got=%0d want=0", curAddr()); end
    total++; if (bus.sample !== 4'b0000) begin bad++; $display("FAIL reset_sample got=%b want=0000", bus.sample); end
    total++; if (bus.valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", bus.valid); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
  endtask

  // Mask 1111, inputs 1010: address j/3 in cycle j after accept, valid at j=12.
  task automatic test_full_scan();
    logic [1:0] expAddr;
    inVec = 4'b1010;
    bus.scan_mask = 4'b1111;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int j = 0; j < 14; j++) begin
      expAddr = (j < 12) ? 2'(j / 3) : 2'd3;
      total++; if (curAddr() !== expAddr) begin bad++; $display("FAIL full_addr j=%0d got=%0d want=%0d", j, curAddr(), expAddr); end
      total++; if (bus.valid !== (j == 12)) begin bad++; $display("FAIL full_valid j=%0d got=%b want=%b", j, bus.valid, (j == 12)); end
      total++; if (bus.busy !== (j <= 12)) begin bad++; $display("FAIL full_busy j=%0d got=%b want=%b", j, bus.busy, (j <= 12)); end
      if (j == 12) begin
        total++; if (bus.sample !== 4'b1010) begin bad++; $display("FAIL full_sample got=%b want=1010", bus.sample); end
      end
      @(negedge clk);
    end
  endtask

  // Mask 0101, inputs 1111: channels 0 then 2, valid at j=6.
  task automatic test_sparse_mask();
    logic [1:0] expAddr;
    inVec = 4'b1111;
    bus.scan_mask = 4'b0101;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int j = 0; j < 8; j++) begin
      expAddr = (j < 3) ? 2'd0 : 2'd2;
      total++; if (curAddr() !== expAddr) begin bad++; $display("FAIL sparse_addr j=%0d got=%0d want=%0d", j, curAddr(), expAddr); end
      total++; if (bus.valid !== (j == 6)) begin bad++; $display("FAIL sparse_valid j=%0d got=%b want=%b", j, bus.valid, (j == 6)); end
      @(negedge clk);
    end
    total++; if (bus.sample !== 4'b0101) begin bad++; $display("FAIL sparse_sample got=%b want=0101", bus.sample); end
  endtask

  // Mask 0000: valid right after accept, sample cleared, address stays at 2.
  task automatic test_zero_mask();
    bus.scan_mask = 4'b0000;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    total++; if (bus.valid !== 1'b1) begin bad++; $display("FAIL zero_valid got=%b want=1", bus.valid); end
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL zero_busy got=%b want=1", bus.busy); end
    total++; if (bus.sample !== 4'b0000) begin bad++; $display("FAIL zero_sample got=%b want=0000", bus.sample); end
    total++; if (curAddr() !== 2'd2) begin bad++; $display("FAIL zero_addr got=%0d want=2", curAddr()); end
    @(negedge clk);
    total++; if (bus.valid !== 1'b0) begin bad++; $display("FAIL zero_valid_end got=%b want=0", bus.valid); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL zero_busy_end got=%b want=0", bus.busy); end
  endtask

  // Second start with mask 0001 mid-scan must be ignored.
  task automatic test_start_while_busy();
    int nValid;
    logic [1:0] expAddr;
    nValid = 0;
    inVec = 4'b0110;
    bus.scan_mask = 4'b1111;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int j = 0; j < 16; j++) begin
      if (j == 4) begin bus.start = 1'b1; bus.scan_mask = 4'b0001; end
      if (j == 5) bus.start = 1'b0;
      expAddr = (j < 12) ? 2'(j / 3) : 2'd3;
      total++; if (curAddr() !== expAddr) begin bad++; $display("FAIL busy_addr j=%0d got=%0d want=%0d", j, curAddr(), expAddr); end
      if (bus.valid === 1'b1) begin
        nValid++;
        total++; if (j != 12) begin bad++; $display("FAIL busy_valid_time got=j%0d want=j12", j); end
      end
      @(negedge clk);
    end
    total++; if (nValid != 1) begin bad++; $display("FAIL busy_valid_count got=%0d want=1", nValid); end
    total++; if (bus.sample !== 4'b0110) begin bad++; $display("FAIL busy_sample got=%b want=0110", bus.sample); end
  endtask

  // Reset on the 5th cycle of a 1111 scan, then a clean rescan.
  task automatic test_reset_mid_scan();
    int nValid;
    nValid = 0;
    inVec = 4'b1010;
    bus.scan_mask = 4'b1111;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", bus.busy); end
    total++; if (curAddr() !== 2'd0) begin bad++; $display("FAIL rst_addr got=%0d want=0", curAddr()); end
    total++; if (bus.sample !== 4'b0000) begin bad++; $display("FAIL rst_sample got=%b want=0000", bus.sample); end
    for (int j = 0; j < 16; j++) begin
      if (bus.valid === 1'b1) nValid++;
      @(negedge clk);
    end
    total++; if (nValid != 0) begin bad++; $display("FAIL rst_no_valid got=%0d want=0", nValid); end
    inVec = 4'b1001;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int j = 0; j < 14; j++) begin
      total++; if (bus.valid !== (j == 12)) begin bad++; $display("FAIL rescan_valid j=%0d got=%b want=%b", j, bus.valid, (j == 12)); end
      @(negedge clk);
    end
    total++; if (bus.sample !== 4'b1001) begin bad++; $display("FAIL rescan_sample got=%b want=1001", bus.sample); end
  endtask

  // Start held high through DONE: re-accept one edge after DONE->IDLE.
  task automatic test_back_to_back();
    bus.scan_mask = 4'b0000;
    bus.start = 1'b1;
    @(negedge clk);
    total++; if (bus.valid !== 1'b1) begin bad++; $display("FAIL b2b_valid0 got=%b want=1", bus.valid); end
    @(negedge clk);
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL b2b_idle_busy got=%b want=0", bus.busy); end
    total++; if (bus.valid !== 1'b0) begin bad++; $display("FAIL b2b_idle_valid got=%b want=0", bus.valid); end
    @(negedge clk);
    bus.start = 1'b0;
    total++; if (bus.valid !== 1'b1) begin bad++; $display("FAIL b2b_valid1 got=%b want=1", bus.valid); end
    @(negedge clk);
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL b2b_end_busy got=%b want=0", bus.busy); end
  endtask

  initial begin
    total = 0;
    bad = 0;
    reset = 1'b1;
    bus.start = 1'b0;
    bus.scan_mask = 4'b0000;
    inVec = 4'b0000;
    test_reset();
    test_full_scan();
    test_sparse_mask();
    test_zero_mask();
    test_start_while_busy();
    test_reset_mid_scan();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
